mcu_sequencer: RTL and testbench

Parametrised instruction sequencer that fetches instruction words from a synchronous program ROM and issues them one at a time to the SCU over a Run/Done handshake. It sits between the program memory and the SCU and replaces the fixed 4-bit counter scheme. Beyond simple fetch-and-issue, it adds:
- configurable address and data widths and ROM latency;
- an end address with wrap or halt;
- a halt opcode;
- single-step mode;
- a completion watchdog.

---
 rtl/mcu_pkg.sv | 21 ++
 rtl/seq_watchdog.sv | 41 ++++
 rtl/mcu_sequencer.sv | 157 +++++++++++++++
 tb/tb_mcu_sequencer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// Shared types and constants for the instruction sequencer: FSM state encoding
// and the default halt opcode.
package mcu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_PAUSE,
    ST_HALT
  } state_e;

  localparam logic [15:0] DEFAULT_HALT_WORD = 16'hFFFF;

  // Busy covers every state in which a program is in flight.
  function automatic logic is_busy(input state_e s);
    return !((s == ST_IDLE) || (s == ST_HALT));
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Completion watchdog: a loadable down-counter that flags expiry on the last
// enabled cycle of a TIMEOUT-cycle window. TIMEOUT = 0 disables it.
module seq_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic srst,
  input  logic clear,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = CW'(TIMEOUT);
    end else if (en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Count of 1 while enabled means this is the final cycle of the window.
  assign expire = (TIMEOUT != 0) && en && (count_q == CW'(1));

endmodule

// File: rtl/mcu_sequencer.sv
// Instruction sequencer: fetches words from a synchronous ROM and issues them
// to the SCU over a Run/Done handshake, with wrap/halt, single-step and watchdog.
module mcu_sequencer
  import mcu_pkg::*;
#(
  parameter int                 ADDR_W     = 4,
  parameter int                 DATA_W     = 16,
  parameter int                 MEM_LAT    = 1,
  parameter logic [ADDR_W-1:0]  START_ADDR = '0,
  parameter logic [DATA_W-1:0]  HALT_WORD  = DATA_W'(DEFAULT_HALT_WORD),
  parameter int                 TIMEOUT    = 255
) (
  input  logic              Mclk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Step_mode,
  input  logic              Step,
  input  logic              Wrap,
  input  logic [ADDR_W-1:0] End_addr,
  output logic [ADDR_W-1:0] Mem_addr,
  input  logic [DATA_W-1:0] Mem_data,
  output logic [DATA_W-1:0] Instr,
  output logic              Run,
  input  logic              Done,
  output logic              Busy,
  output logic              Halted,
  output logic              Error,
  output logic [ADDR_W-1:0] Pc
);

  localparam int             LW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [LW-1:0]  LAT_LAST = LW'(MEM_LAT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic              error_q, error_d;
  logic              done_q;
  logic              done_rise;
  logic              wd_clear, wd_load, wd_en, wd_expire;
  logic [ADDR_W-1:0] pc_next;

  assign done_rise = Done & ~done_q;

  // Successor address; at End_addr this only matters when Wrap is set.
  assign pc_next = (pc_q == End_addr) ? START_ADDR : pc_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mem_addr_d = mem_addr_q;
    instr_d    = instr_q;
    lat_d      = lat_q;
    error_d    = error_q;
    wd_clear   = 1'b0;
    wd_load    = 1'b0;
    wd_en      = 1'b0;

    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (Start) begin
          state_d    = ST_FETCH;
          pc_d       = START_ADDR;
          mem_addr_d = START_ADDR;
          lat_d      = '0;
          error_d    = 1'b0;
        end
      end

      ST_FETCH: begin
        if (lat_q == LAT_LAST) begin
          instr_d = Mem_data;
          state_d = (Mem_data == HALT_WORD) ? ST_HALT : ST_ISSUE;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end

      ST_ISSUE: begin
        wd_load = 1'b1;
        state_d = ST_WAIT_DONE;
      end

      ST_WAIT_DONE: begin
        wd_en = 1'b1;
        // A completion in the same cycle as expiry still counts as completion.
        if (done_rise) begin
          wd_clear = 1'b1;
          if ((pc_q == End_addr) && !Wrap) begin
            state_d = ST_HALT;
          end else begin
            pc_d       = pc_next;
            mem_addr_d = pc_next;
            lat_d      = '0;
            state_d    = Step_mode ? ST_PAUSE : ST_FETCH;
          end
        end else if (wd_expire) begin
          error_d = 1'b1;
          state_d = ST_HALT;
        end
      end

      ST_PAUSE: begin
        if (Step || !Step_mode) begin
          lat_d   = '0;
          state_d = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Mclk) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= START_ADDR;
      mem_addr_q <= START_ADDR;
      instr_q    <= '0;
      lat_q      <= '0;
      error_q    <= 1'b0;
      done_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mem_addr_q <= mem_addr_d;
      instr_q    <= instr_d;
      lat_q      <= lat_d;
      error_q    <= error_d;
      done_q     <= Done;
    end
  end

  seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (Mclk),
    .srst   (Reset),
    .clear  (wd_clear),
    .load   (wd_load),
    .en     (wd_en),
    .expire (wd_expire)
  );

  assign Mem_addr = mem_addr_q;
  assign Instr    = instr_q;
  assign Run      = (state_q == ST_ISSUE);
  assign Busy     = is_busy(state_q);
  assign Halted   = (state_q == ST_HALT);
  assign Error    = error_q;
  assign Pc       = pc_q;

endmodule

// File: tb/tb_mcu_sequencer.sv
// Self-checking bench for mcu_sequencer: a registered ROM model, an SCU model
// driving Done, and a program-walk reference for the expected issue stream.
module tb_mcu_sequencer;

  localparam int          AW  = 4;
  localparam int          DW  = 16;
  localparam int          LAT = 2;
  localparam int          TO  = 8;
  localparam logic [15:0] HW  = 16'hFFFF;

  logic          Mclk = 1'b0;
  logic          Reset = 1'b1;
  logic          Start = 1'b0;
  logic          Step_mode = 1'b0;
  logic          Step = 1'b0;
  logic          Wrap = 1'b0;
  logic          Done = 1'b0;
  logic [AW-1:0] End_addr = '0;
  logic [AW-1:0] Mem_addr;
  logic [DW-1:0] Mem_data;
  logic [DW-1:0] Instr;
  logic          Run, Busy, Halted, Error;
  logic [AW-1:0] Pc;

  logic [DW-1:0] rom [16];
  logic [DW-1:0] rom_q = '0;
  int            dly [64];
  int            vectors = 0;
  int            miscompares = 0;

  always #5 Mclk = ~Mclk;

  // One register stage plus the capture edge gives a LAT=2 ROM.
  always @(posedge Mclk) rom_q <= rom[Mem_addr];
  assign Mem_data = rom_q;

  mcu_sequencer #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .MEM_LAT    (LAT),
    .START_ADDR (4'd0),
    .HALT_WORD  (HW),
    .TIMEOUT    (TO)
  ) dut (
    .Mclk      (Mclk),
    .Reset     (Reset),
    .Start     (Start),
    .Step_mode (Step_mode),
    .Step      (Step),
    .Wrap      (Wrap),
    .End_addr  (End_addr),
    .Mem_addr  (Mem_addr),
    .Mem_data  (Mem_data),
    .Instr     (Instr),
    .Run       (Run),
    .Done      (Done),
    .Busy      (Busy),
    .Halted    (Halted),
    .Error     (Error),
    .Pc        (Pc)
  );

  typedef struct {
    logic [3:0]  end_a;
    bit          wrap;
    int          halt_at;
    int          to_at;
    int          max_runs;
    int          exp_runs;
    logic [3:0]  exp_pc;
    logic [15:0] exp_instr;
    bit          exp_err;
    bit          exp_halt;
  } vec_t;

  vec_t tab [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1; Start = 1'b0; Step = 1'b0; Done = 1'b0;
    repeat (2) @(negedge Mclk);
    Reset = 1'b0;
  endtask

  task automatic fill_rom_linear();
    for (int i = 0; i < 16; i++) rom[i] = 16'hA0A0 + 16'(i);
  endtask

  // Called on the negedge where the trigger (Start, Done, Step) was raised:
  // the fetched word must appear MEM_LAT+1 negedges later.
  task automatic wait_fetch(input logic [3:0] pc, output bit hw);
    for (int i = 0; i < LAT; i++) begin
      @(negedge Mclk);
      Start = 1'b0; Done = 1'b0; Step = 1'b0;
      chk("fetch_run_err_busy", {Run, Error, Busy}, 3'b001);
    end
    @(negedge Mclk);
    if (rom[pc] == HW) begin
      chk("hw_halt_run", {Halted, Run}, 2'b10);
      chk("hw_pc", Pc, pc);
      chk("hw_instr", Instr, HW);
      hw = 1'b1;
    end else begin
      chk("issue_run", Run, 1);
      chk("issue_instr", Instr, rom[pc]);
      chk("issue_pc", Pc, pc);
      hw = 1'b0;
    end
  endtask

  // Reference walk of the program: issue stream, end-address wrap/halt,
  // halt opcode and watchdog, while acting as the SCU.
  task automatic play(input logic [3:0] end_a, input bit wrap, input int max_runs,
                      output int runs);
    logic [3:0] pc;
    bit fin, hw;
    int d;
    pc = 4'd0; runs = 0; fin = 1'b0;
    End_addr = end_a; Wrap = wrap;
    Start = 1'b1;
    while (!fin) begin
      wait_fetch(pc, hw);
      if (hw) begin
        fin = 1'b1;
      end else begin
        runs++;
        d = dly[(runs - 1) % 64];
        if (runs >= max_runs) begin
          fin = 1'b1;
        end else if (d > TO) begin
          for (int i = 0; i < TO; i++) begin
            @(negedge Mclk);
            Start = ($urandom_range(0, 3) == 0);
            chk("wd_not_yet", {Error, Halted}, 2'b00);
          end
          @(negedge Mclk);
          Start = 1'b0;
          chk("wd_err_halt", {Error, Halted}, 2'b11);
          chk("wd_pc", Pc, pc);
          fin = 1'b1;
        end else begin
          for (int i = 0; i < d - 1; i++) begin
            @(negedge Mclk);
            Start = ($urandom_range(0, 3) == 0);
            chk("wait_busy", {Busy, Halted, Run}, 3'b100);
          end
          @(negedge Mclk);
          Start = 1'b0; Done = 1'b1;
          if ((pc == end_a) && !wrap) begin
            @(negedge Mclk);
            Done = 1'b0;
            chk("end_halt", {Halted, Run, Error}, 3'b100);
            chk("end_pc", Pc, pc);
            fin = 1'b1;
          end else begin
            pc = (pc == end_a) ? 4'd0 : pc + 4'd1;
          end
        end
      end
    end
    Start = 1'b0;
  endtask

  initial begin
    int runs;
    bit hw;

    tab[0] = '{4'd3,  1'b0, -1, -1, 40,  4, 4'd3,  16'hA0A3, 1'b0, 1'b1};
    tab[1] = '{4'd5,  1'b0,  2, -1, 40,  2, 4'd2,  16'hFFFF, 1'b0, 1'b1};
    tab[2] = '{4'd0,  1'b0, -1, -1, 40,  1, 4'd0,  16'hA0A0, 1'b0, 1'b1};
    tab[3] = '{4'd15, 1'b0, -1, -1, 40, 16, 4'd15, 16'hA0AF, 1'b0, 1'b1};
    tab[4] = '{4'd4,  1'b0, -1,  2, 40,  3, 4'd2,  16'hA0A2, 1'b1, 1'b1};
    tab[5] = '{4'd3,  1'b1, -1, -1, 12, 12, 4'd3,  16'hA0A3, 1'b0, 1'b0};
    tab[6] = '{4'd3,  1'b0,  0, -1, 40,  0, 4'd0,  16'hFFFF, 1'b0, 1'b1};
    tab[7] = '{4'd1,  1'b1, -1,  3, 40,  4, 4'd1,  16'hA0A1, 1'b1, 1'b1};
    tab[8] = '{4'd14, 1'b1, 15, -1, 20, 20, 4'd4,  16'hA0A4, 1'b0, 1'b0};

    fill_rom_linear();

    // Reset with Done stuck high, then a stuck Done must not complete.
    Reset = 1'b1; Done = 1'b1;
    repeat (3) @(negedge Mclk);
    chk("rst_flags", {Busy, Run, Halted, Error}, 4'b0000);
    chk("rst_pc_addr", {Pc, Mem_addr}, 8'h00);
    chk("rst_instr", Instr, 16'h0000);
    Reset = 1'b0;
    @(negedge Mclk);
    chk("idle_flags", {Busy, Run, Halted}, 3'b000);
    End_addr = 4'd3; Wrap = 1'b0;
    Start = 1'b1;
    for (int i = 0; i < LAT; i++) begin
      @(negedge Mclk);
      Start = 1'b0;
      chk("first_run_early", Run, 0);
    end
    @(negedge Mclk);
    chk("first_run", {Run, Pc}, {1'b1, 4'd0});
    for (int i = 0; i < 3; i++) begin
      @(negedge Mclk);
      chk("stuck_done_ignored", {Run, Busy, Halted, Pc}, {3'b010, 4'd0});
    end
    @(negedge Mclk);
    Done = 1'b0;
    @(negedge Mclk);
    chk("still_waiting", {Run, Pc}, {1'b0, 4'd0});
    Done = 1'b1;
    wait_fetch(4'd1, hw);
    @(negedge Mclk);
    Reset = 1'b1;
    @(negedge Mclk);
    Reset = 1'b0;
    chk("midrun_rst_flags", {Busy, Run, Halted, Error}, 4'b0000);
    chk("midrun_rst_pc", {Pc, Mem_addr}, 8'h00);
    $display("stuck-done/reset sequence done");

    // Table-driven programs; restart from HALT directly, otherwise reset.
    for (int v = 0; v < 9; v++) begin
      if (!Halted) do_reset();
      fill_rom_linear();
      if (tab[v].halt_at >= 0) rom[tab[v].halt_at] = HW;
      for (int i = 0; i < 64; i++) dly[i] = 3;
      if (tab[v].to_at >= 0) dly[tab[v].to_at] = 10;
      play(tab[v].end_a, tab[v].wrap, tab[v].max_runs, runs);
      chk("tab_runs", runs, tab[v].exp_runs);
      chk("tab_pc", Pc, tab[v].exp_pc);
      chk("tab_instr", Instr, tab[v].exp_instr);
      chk("tab_err_halt", {Error, Halted}, {tab[v].exp_err, tab[v].exp_halt});
      $display("vector %0d: end=%0d wrap=%0d runs=%0d pc=%0d instr=%h err=%0d",
               v, tab[v].end_a, tab[v].wrap, runs, Pc, Instr, Error);
    end

    // Single-step: PAUSE holds, Start is ignored, Step or Step_mode drop resumes.
    do_reset();
    fill_rom_linear();
    Step_mode = 1'b1; End_addr = 4'd3; Wrap = 1'b0;
    Start = 1'b1;
    wait_fetch(4'd0, hw);
    @(negedge Mclk);
    @(negedge Mclk);
    Done = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Mclk);
      Done = 1'b0;
      Start = (i == 4);
      chk("pause_hold", {Run, Busy, Halted, Pc}, {3'b010, 4'd1});
    end
    Start = 1'b0;
    Step = 1'b1;
    wait_fetch(4'd1, hw);
    @(negedge Mclk);
    Done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Mclk);
      Done = 1'b0;
      chk("pause2_hold", {Run, Busy, Pc}, {2'b01, 4'd2});
    end
    Step_mode = 1'b0;
    wait_fetch(4'd2, hw);
    @(negedge Mclk);
    Done = 1'b1;
    wait_fetch(4'd3, hw);
    @(negedge Mclk);
    Done = 1'b1;
    @(negedge Mclk);
    Done = 1'b0;
    chk("step_end_halt", {Halted, Pc}, {1'b1, 4'd3});
    $display("single-step sequence done");

    // Randomized programs against the program-walk reference.
    for (int r = 0; r < 12; r++) begin
      logic [3:0] e;
      bit w;
      if (!Halted) do_reset();
      for (int i = 0; i < 16; i++) begin
        rom[i] = 16'($urandom);
        if (rom[i] == HW) rom[i] = 16'h1234;
        if ($urandom_range(0, 11) == 0) rom[i] = HW;
      end
      for (int i = 0; i < 64; i++)
        dly[i] = ($urandom_range(0, 19) == 0) ? 9 + $urandom_range(0, 3) : $urandom_range(1, 8);
      e = 4'($urandom_range(0, 15));
      w = 1'($urandom_range(0, 1));
      play(e, w, 30, runs);
      $display("random %0d: end=%0d wrap=%0d runs=%0d pc=%0d halted=%0d err=%0d",
               r, e, w, runs, Pc, Halted, Error);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
